// File: rtl/knapsack_solver.sv
// Iterative 0/1 knapsack engine: a 1-D DP table held in registers, updated one
// (item, capacity) cell per clock while the capacity index walks downward.
module knapsack_solver #(
  parameter int N_ITEMS = 4,
  parameter int CAP_W   = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [CAP_W-1:0]           capacity,
  input  logic [N_ITEMS*CAP_W-1:0]   weights,
  input  logic [N_ITEMS*8-1:0]       values,
  output logic [7:0]                 result,
  output logic                       done,
  output logic                       busy
);
  localparam int DEPTH = 1 << CAP_W;
  localparam int IW    = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1;

  typedef enum logic [1:0] {IDLE, INIT, SCAN, DONE} state_t;

  state_t                          state;
  logic [CAP_W-1:0]                cap_q, c;
  logic [IW-1:0]                   i;
  logic [N_ITEMS-1:0][CAP_W-1:0]   w_q;
  logic [N_ITEMS-1:0][7:0]         v_q;
  logic [DEPTH-1:0][7:0]           dp;

  logic [CAP_W-1:0] wi;
  logic [7:0]       vi, cur, src, cand, upd;
  logic [8:0]       sum9;
  logic             fits, last_item;

  // Cell update: compare the current entry against taking item i on top of
  // the entry w_q[i] below it; the source is read before this edge's write.
  always_comb begin
    wi        = w_q[i];
    vi        = v_q[i];
    cur       = dp[c];
    fits      = (c >= wi);
    src       = dp[c - wi];
    sum9      = {1'b0, src} + {1'b0, vi};
    cand      = sum9[8] ? 8'hFF : sum9[7:0];
    upd       = (fits && cand > cur) ? cand : cur;
    last_item = (i == IW'(N_ITEMS - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cap_q  <= '0;
      c      <= '0;
      i      <= '0;
      w_q    <= '0;
      v_q    <= '0;
      dp     <= '0;
      result <= '0;
      done   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          cap_q <= capacity;
          w_q   <= weights;
          v_q   <= values;
          busy  <= 1'b1;
          state <= INIT;
        end
        INIT: begin
          dp    <= '0;
          i     <= '0;
          c     <= cap_q;
          state <= SCAN;
        end
        SCAN: begin
          dp[c] <= upd;
          if (c == '0) begin
            if (last_item) state <= DONE;
            else begin
              i <= i + 1'b1;
              c <= cap_q;
            end
          end else begin
            c <= c - 1'b1;
          end
        end
        DONE: begin
          result <= dp[cap_q];
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_knapsack_solver.sv
// Scoreboard bench for knapsack_solver: a brute-force subset model supplies
// the expected optimum and latency for every accepted solve.
module tb_knapsack_solver;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  capacity = '0;
  logic [15:0] weights = '0;
  logic [31:0] values = '0;
  logic [7:0]  result;
  logic        done, busy;

  int checks = 0;
  int failures = 0;

  typedef struct { int res; int lat; } exp_t;
  exp_t exp_q[$];

  knapsack_solver #(.N_ITEMS(4), .CAP_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .capacity(capacity),
    .weights(weights), .values(values), .result(result), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int model(input int cap, input int w[4], input int v[4]);
    int best = 0;
    for (int m = 0; m < 16; m++) begin
      int ws = 0;
      int vs = 0;
      for (int k = 0; k < 4; k++) if (m[k]) begin ws += w[k]; vs += v[k]; end
      if (ws <= cap && vs > best) best = vs;
    end
    return (best > 255) ? 255 : best;
  endfunction

  // Drives one start pulse; returns #1 after the accepting edge.
  task automatic start_solve(input int cap, input int w[4], input int v[4]);
    exp_t e;
    @(negedge clk);
    capacity = cap[3:0];
    for (int k = 0; k < 4; k++) begin
      weights[k*4 +: 4] = w[k][3:0];
      values[k*8 +: 8]  = v[k][7:0];
    end
    start = 1'b1;
    e.res = model(cap, w, v);
    e.lat = 4 * (cap + 1) + 2;
    exp_q.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int n, output int bc, output bit to);
    n = 0; bc = 0; to = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      #1 n++;
      if (done) begin to = 1'b0; break; end
      if (busy) bc++;
    end
  endtask

  task automatic test_reset;
    #2;
    checks++; if (result !== 8'h00) begin failures++; $display("FAIL reset_result got=%h exp=00", result); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int w[4]; int v[4]; int n; int bc; bit to; exp_t e;
    w = '{2, 3, 4, 5}; v = '{3, 4, 5, 6};
    start_solve(5, w, v);
    bc = busy ? 1 : 0;
    wait_done(n, bc, to);
    bc += (busy ? 0 : 0);
    e = exp_q.pop_front();
    checks++; if (to) begin failures++; $display("FAIL basic_timeout no done"); end
    checks++; if (n != e.lat) begin failures++; $display("FAIL basic_latency got=%0d exp=%0d", n, e.lat); end
    checks++; if (result !== e.res[7:0]) begin failures++; $display("FAIL basic_result got=%h exp=%h", result, e.res[7:0]); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_at_done got=%b exp=0", busy); end
    checks++; if (bc + 1 != 26) begin failures++; $display("FAIL basic_busy_cycles got=%0d exp=26", bc + 1); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_saturation;
    int w[4]; int v[4]; int n; int bc; bit to; exp_t e;
    w = '{1, 1, 1, 1}; v = '{200, 100, 50, 10};
    start_solve(4, w, v);
    wait_done(n, bc, to);
    e = exp_q.pop_front();
    checks++; if (to || n != e.lat) begin failures++; $display("FAIL sat_latency got=%0d exp=%0d", n, e.lat); end
    checks++; if (result !== e.res[7:0]) begin failures++; $display("FAIL sat_result got=%h exp=%h", result, e.res[7:0]); end
  endtask

  task automatic test_nofit;
    int w[4]; int v[4]; int n; int bc; bit to; exp_t e;
    w = '{9, 10, 11, 12}; v = '{7, 8, 9, 10};
    start_solve(8, w, v);
    wait_done(n, bc, to);
    e = exp_q.pop_front();
    checks++; if (to || n != e.lat) begin failures++; $display("FAIL nofit_latency got=%0d exp=%0d", n, e.lat); end
    checks++; if (result !== e.res[7:0]) begin failures++; $display("FAIL nofit_result got=%h exp=%h", result, e.res[7:0]); end
  endtask

  task automatic test_zero_cap;
    int w[4]; int v[4]; int n; int bc; bit to; exp_t e;
    w = '{0, 3, 0, 2}; v = '{5, 9, 7, 1};
    start_solve(0, w, v);
    wait_done(n, bc, to);
    e = exp_q.pop_front();
    checks++; if (to || n != e.lat) begin failures++; $display("FAIL zcap_latency got=%0d exp=%0d", n, e.lat); end
    checks++; if (result !== e.res[7:0]) begin failures++; $display("FAIL zcap_result got=%h exp=%h", result, e.res[7:0]); end
  endtask

  task automatic test_start_busy;
    int w[4]; int v[4]; int n; int n2; int bc; bit to; exp_t e;
    w = '{2, 3, 4, 5}; v = '{3, 4, 5, 6};
    start_solve(5, w, v);
    n = 0;
    repeat (4) begin @(posedge clk); #1 n++; end
    capacity = 4'd15; weights = 16'h1111; values = 32'hFFFF_FFFF;
    start = 1'b1;
    @(posedge clk); #1 n++;
    start = 1'b0;
    wait_done(n2, bc, to);
    e = exp_q.pop_front();
    checks++; if (to || n + n2 != e.lat) begin failures++; $display("FAIL busy_latency got=%0d exp=%0d", n + n2, e.lat); end
    checks++; if (result !== e.res[7:0]) begin failures++; $display("FAIL busy_result got=%h exp=%h", result, e.res[7:0]); end
  endtask

  task automatic test_back_to_back;
    int w[4]; int v[4]; int n; int bc; bit to; exp_t e; exp_t e2;
    w = '{2, 3, 4, 5}; v = '{3, 4, 5, 6};
    start_solve(5, w, v);
    wait_done(n, bc, to);
    e = exp_q.pop_front();
    checks++; if (to || result !== e.res[7:0]) begin failures++; $display("FAIL b2b_first got=%h exp=%h", result, e.res[7:0]); end
    // still inside the done cycle: present the next request now
    w = '{4, 4, 4, 4}; v = '{1, 2, 3, 4};
    capacity = 4'd15;
    for (int k = 0; k < 4; k++) begin
      weights[k*4 +: 4] = w[k][3:0];
      values[k*8 +: 8]  = v[k][7:0];
    end
    start = 1'b1;
    e2.res = model(15, w, v);
    e2.lat = 4 * 16 + 2;
    exp_q.push_back(e2);
    @(posedge clk); #1 start = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_accept busy got=%b exp=1", busy); end
    checks++; if (done !== 1'b0 || result !== e.res[7:0]) begin failures++; $display("FAIL b2b_hold done=%b result=%h exp_result=%h", done, result, e.res[7:0]); end
    wait_done(n, bc, to);
    e2 = exp_q.pop_front();
    checks++; if (to || n != e2.lat) begin failures++; $display("FAIL b2b_latency got=%0d exp=%0d", n, e2.lat); end
    checks++; if (result !== e2.res[7:0]) begin failures++; $display("FAIL b2b_result got=%h exp=%h", result, e2.res[7:0]); end
  endtask

  task automatic test_reset_mid;
    int w[4]; int v[4]; int n; int bc; bit to; exp_t e;
    w = '{2, 3, 4, 5}; v = '{3, 4, 5, 6};
    start_solve(5, w, v);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    void'(exp_q.pop_front());
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rstmid_done got=%b exp=0", done); end
    checks++; if (result !== 8'h00) begin failures++; $display("FAIL rstmid_result got=%h exp=00", result); end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0 || result !== 8'h00) begin failures++; $display("FAIL rstmid_idle busy=%b result=%h exp busy=0 result=00", busy, result); end
    start_solve(5, w, v);
    wait_done(n, bc, to);
    e = exp_q.pop_front();
    checks++; if (to || n != e.lat) begin failures++; $display("FAIL rstmid_latency got=%0d exp=%0d", n, e.lat); end
    checks++; if (result !== e.res[7:0]) begin failures++; $display("FAIL rstmid_result2 got=%h exp=%h", result, e.res[7:0]); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_saturation;
    test_nofit;
    test_zero_cap;
    test_start_busy;
    test_back_to_back;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
